// File: rtl/serial_word_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_word_adder_pkg
//  Description : Shared state encoding and count-width helper for the
//                serial wide-word adder/subtractor.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_word_adder_pkg;

    localparam int c_st_w = 2;

    localparam logic [c_st_w-1:0] c_st_idle = 2'd0;
    localparam logic [c_st_w-1:0] c_st_run  = 2'd1;
    localparam logic [c_st_w-1:0] c_st_done = 2'd2;

    // Slice counter must be able to represent 0..WORDS.
    function automatic int cnt_width(input int words);
        return $clog2(words + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/nbit_slice_adder.sv
`default_nettype none
// ============================================================================
//  Module      : nbit_slice_adder
//  Description : Purely combinational N-bit adder slice with carry in/out.
//  Revision    : 1.0 - initial release
// ============================================================================
module nbit_slice_adder #(
    parameter int N = 4
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_cin,
    output logic [N-1:0] o_sum,
    output logic         o_cout
);

    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{N{1'b0}}, i_cin};

endmodule
`default_nettype wire

// File: rtl/serial_word_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_word_adder
//  Description : Wide add/subtract sequenced one N-bit slice per clock,
//                LSB slice first, with a registered result and done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_word_adder
    import serial_word_adder_pkg::*;
#(
    parameter int N     = 4,
    parameter int WORDS = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 start_in,
    input  logic                 sub_in,
    input  logic [N*WORDS-1:0]   a_in,
    input  logic [N*WORDS-1:0]   b_in,
    output logic                 busy_out,
    output logic                 done_out,
    output logic [N*WORDS-1:0]   sum_out,
    output logic                 carry_out
);

    localparam int W  = N * WORDS;
    localparam int CW = cnt_width(WORDS);
    localparam logic [CW-1:0] c_cnt_last = CW'(WORDS - 1);

    logic [c_st_w-1:0] r_state;
    logic [c_st_w-1:0] w_state_nxt;
    logic              w_accept;
    logic              w_last;

    logic [W-1:0]      r_a_sh;
    logic [W-1:0]      r_b_sh;
    logic [W-1:0]      r_acc_sh;
    logic              r_carry;
    logic [CW-1:0]     r_cnt;
    logic [W-1:0]      r_sum;
    logic              r_carry_out;

    logic [N-1:0]      w_slice_sum;
    logic              w_slice_cout;

    nbit_slice_adder #(
        .N (N)
    ) u_slice (
        .i_a    (r_a_sh[N-1:0]),
        .i_b    (r_b_sh[N-1:0]),
        .i_cin  (r_carry),
        .o_sum  (w_slice_sum),
        .o_cout (w_slice_cout)
    );

    // DONE accepts a new start exactly like IDLE, so back-to-back ops have no bubble.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (start_in) begin
                    w_accept    = 1'b1;
                    w_state_nxt = c_st_run;
                end
            end
            c_st_run: begin
                if (r_cnt == c_cnt_last) begin
                    w_last      = 1'b1;
                    w_state_nxt = c_st_done;
                end
            end
            c_st_done: begin
                if (start_in) begin
                    w_accept    = 1'b1;
                    w_state_nxt = c_st_run;
                end else begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Subtract is A + ~B + 1: invert B at load and seed the carry chain with 1.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_acc_sh    <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_carry_out <= 1'b0;
        end else if (w_accept) begin
            r_a_sh  <= a_in;
            r_b_sh  <= sub_in ? ~b_in : b_in;
            r_carry <= sub_in;
            r_cnt   <= '0;
        end else if (r_state == c_st_run) begin
            r_acc_sh <= {w_slice_sum, r_acc_sh[W-1:N]};
            r_a_sh   <= r_a_sh >> N;
            r_b_sh   <= r_b_sh >> N;
            r_carry  <= w_slice_cout;
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) begin
                r_sum       <= {w_slice_sum, r_acc_sh[W-1:N]};
                r_carry_out <= w_slice_cout;
            end
        end
    end

    assign busy_out  = (r_state == c_st_run);
    assign done_out  = (r_state == c_st_done);
    assign sum_out   = r_sum;
    assign carry_out = r_carry_out;

endmodule
`default_nettype wire
